// File: rtl/lms_pkg.sv
// lms_pkg: FSM states, mode codes and saturation
// helper shared by the LMS noise canceller.
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    RESULT,
    UPDATE
  } state_e;

  localparam logic [1:0] MODE_FROZEN    = 2'b00;
  localparam logic [1:0] MODE_SIGN_DATA = 2'b01;
  localparam logic [1:0] MODE_LMS       = 2'b10;
  localparam logic [1:0] MODE_SIGN_SIGN = 2'b11;

  // Wide enough for any legal DATA_W/COEF_W mix.
  localparam int SAT_W = 128;

  // Clamp v to the signed range of w bits.
  function automatic logic signed [SAT_W-1:0] sat_s(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_mac.sv
// lms_mac: signed DATA_W x COEF_W multiplier shared by
// the MAC pass and the full-LMS weight update.
// Ports: a_i sample, b_i weight or error, p_o product.
module lms_mac #(
  parameter int A_W = 16,
  parameter int B_W = 32
) (
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] p_o
);

  localparam int PW = A_W + B_W;

  assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/lms_adaptive_filter.sv
// lms_adaptive_filter: sequential one-tap-per-cycle LMS
// noise canceller. In: clk, reset, sample_valid,
// primary_in, ref_in, mode, coef_clr. Out: ready,
// out_valid, audio_out (error), y_out, overrun.
module lms_adaptive_filter
  import lms_pkg::*;
#(
  parameter int NTAPS    = 8,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 32,
  parameter int MU_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] primary_in,
  input  logic [DATA_W-1:0] ref_in,
  input  logic [1:0]        mode,
  input  logic              coef_clr,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] audio_out,
  output logic [DATA_W-1:0] y_out,
  output logic              overrun
);

  localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int WD    = COEF_W + DATA_W + 2;
  localparam logic signed [WD-1:0] SS_STEP =
    (MU_SHIFT <= COEF_W - 2) ?
    (WD'(1) <<< (COEF_W - 2 - MU_SHIFT)) : '0;

  state_e state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic tap_last;

  logic [DATA_W-1:0] x_q [NTAPS];
  logic [COEF_W-1:0] w_q [NTAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic [DATA_W-1:0] prim_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] e_q;
  logic [1:0] mode_q;
  logic ov_q;
  logic ovr_q;

  logic signed [DATA_W-1:0] mul_a;
  logic signed [COEF_W-1:0] mul_b;
  logic signed [PW-1:0] prod;

  logic signed [ACC_W-1:0] y_full;
  logic signed [DATA_W-1:0] y_sat;
  logic signed [DATA_W-1:0] e_sat;

  logic x_zero, x_neg, e_zero, e_neg;
  logic signed [WD-1:0] e_w;
  logic signed [WD-1:0] d_sd, d_lms, d_ss, delta;
  logic signed [COEF_W-1:0] w_upd;

  // Same multiplier: w*x during MAC, e*x during UPDATE.
  assign mul_a = x_q[tap_q];
  assign mul_b = (state_q == MAC) ?
                 w_q[tap_q] : COEF_W'($signed(e_q));

  lms_mac #(
    .A_W(DATA_W),
    .B_W(COEF_W)
  ) u_mac (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(prod)
  );

  assign tap_last = (tap_q == TAP_W'(NTAPS - 1));

  assign y_full = acc_q >>> (COEF_W - 2);
  assign y_sat  = DATA_W'(sat_s(SAT_W'(y_full), DATA_W));
  assign e_sat  = DATA_W'(sat_s(
                    SAT_W'($signed(prim_q)) - SAT_W'(y_sat),
                    DATA_W));

  always_comb begin
    x_zero = (mul_a == '0);
    x_neg  = mul_a[DATA_W-1];
    e_zero = (e_q == '0);
    e_neg  = e_q[DATA_W-1];
    e_w    = WD'($signed(e_q)) <<< (COEF_W - DATA_W - 1);
    d_sd   = '0;
    if (!x_zero)
      d_sd = (x_neg ? -e_w : e_w) >>> MU_SHIFT;
    d_lms  = (WD'(prod) <<< (COEF_W - 2 * DATA_W))
             >>> MU_SHIFT;
    d_ss   = '0;
    if (!x_zero && !e_zero)
      d_ss = (x_neg ^ e_neg) ? -SS_STEP : SS_STEP;
    delta  = '0;
    unique case (mode_q)
      MODE_FROZEN:    delta = '0;
      MODE_SIGN_DATA: delta = d_sd;
      MODE_LMS:       delta = d_lms;
      MODE_SIGN_SIGN: delta = d_ss;
      default:        delta = '0;
    endcase
    w_upd = COEF_W'(sat_s(
              SAT_W'($signed(w_q[tap_q])) + SAT_W'(delta),
              COEF_W));
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    unique case (state_q)
      IDLE: begin
        // Clear wins over a simultaneous strobe.
        if (sample_valid && !coef_clr) state_d = LOAD;
      end
      LOAD: begin
        state_d = MAC;
        tap_d   = '0;
      end
      MAC: begin
        if (tap_last) begin
          state_d = RESULT;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      RESULT: state_d = UPDATE;
      UPDATE: begin
        if (tap_last) begin
          state_d = IDLE;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      prim_q  <= '0;
      y_q     <= '0;
      e_q     <= '0;
      mode_q  <= MODE_FROZEN;
      ov_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ov_q    <= 1'b0;
      ovr_q   <= sample_valid &&
                 ((state_q != IDLE) || coef_clr);
      unique case (state_q)
        IDLE: begin
          if (coef_clr) begin
            for (int k = 0; k < NTAPS; k++) begin
              x_q[k] <= '0;
              w_q[k] <= '0;
            end
          end
        end
        LOAD: begin
          for (int k = NTAPS - 1; k > 0; k--)
            x_q[k] <= x_q[k-1];
          x_q[0] <= ref_in;
          prim_q <= primary_in;
          mode_q <= mode;
          acc_q  <= '0;
        end
        MAC: acc_q <= acc_q + ACC_W'(prod);
        RESULT: begin
          y_q  <= y_sat;
          e_q  <= e_sat;
          ov_q <= 1'b1;
        end
        UPDATE: w_q[tap_q] <= w_upd;
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign out_valid = ov_q;
  assign overrun   = ovr_q;
  assign audio_out = e_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_lms_adaptive_filter.sv
// tb_lms_adaptive_filter: directed vectors with hand-made
// expectations for timing, modes, saturation, convergence.
module tb_lms_adaptive_filter;

  logic clk = 1'b0;
  logic reset;
  logic sample_valid;
  logic coef_clr;
  logic [1:0] mode;
  logic [15:0] primary_in;
  logic [15:0] ref_in;
  logic ready;
  logic out_valid;
  logic overrun;
  logic [15:0] audio_out;
  logic [15:0] y_out;

  int errs = 0;
  int checks = 0;
  int lat;
  int rlat;
  logic [15:0] yo, eo;

  always #5 clk = ~clk;

  lms_adaptive_filter #(
    .NTAPS(8),
    .DATA_W(16),
    .COEF_W(32),
    .MU_SHIFT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .primary_in(primary_in),
    .ref_in(ref_in),
    .mode(mode),
    .coef_clr(coef_clr),
    .ready(ready),
    .out_valid(out_valid),
    .audio_out(audio_out),
    .y_out(y_out),
    .overrun(overrun)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    coef_clr = 1'b1;
    tick();
    coef_clr = 1'b0;
  endtask

  // One sample; inj adds a strobe plus mode/input
  // changes while the sample is in MAC.
  task automatic send(input logic [1:0] m,
                      input logic [15:0] p,
                      input logic [15:0] r,
                      input bit inj,
                      output logic [15:0] yv,
                      output logic [15:0] ev);
    int n;
    bit got;
    n = 0;
    yv = '0;
    ev = '0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    if (!ready) chk("ready_wait_timeout", 0, 1);
    mode = m;
    primary_in = p;
    ref_in = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (inj && n == 1) begin
        sample_valid = 1'b1;
        mode = 2'b00;
        primary_in = 16'h7000;
        ref_in = 16'h7000;
      end
      if (inj && n == 2) begin
        sample_valid = 1'b0;
        chk("inj_ovr_pulse", overrun, 1);
        mode = m;
        primary_in = p;
        ref_in = r;
      end
      if (inj && n == 3) chk("inj_ovr_end", overrun, 0);
      if (out_valid) begin
        got = 1;
        lat = n;
        yv = y_out;
        ev = audio_out;
      end
    end
    if (!got) chk("out_valid_timeout", 0, 1);
    while (!ready && n < 80) begin
      tick();
      n++;
    end
    rlat = n;
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int w0;
    int rs;
    int ph;
    logic signed [15:0] es;

    reset = 1'b1;
    sample_valid = 1'b0;
    coef_clr = 1'b0;
    mode = 2'b00;
    primary_in = '0;
    ref_in = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_y", y_out, 0);

    // Frozen mode, zero weights.
    send(2'b00, 16'h1000, 16'h2000, 0, yo, eo);
    chk("frz_latency", lat, 10);
    chk("frz_next_ready", rlat, 18);
    chk("frz_y", yo, 16'h0000);
    chk("frz_audio", eo, 16'h1000);
    chk("frz_w0", dut.w_q[0], 0);

    // Sign-data step from a cleared filter.
    clr();
    send(2'b01, 16'h4000, 16'h4000, 0, yo, eo);
    chk("sd_audio", eo, 16'h4000);
    chk("sd_w0", dut.w_q[0], 32'h0800_0000);
    chk("sd_w1", dut.w_q[1], 0);

    // Clear beats a simultaneous strobe.
    coef_clr = 1'b1;
    sample_valid = 1'b1;
    ref_in = 16'h1234;
    tick();
    coef_clr = 1'b0;
    sample_valid = 1'b0;
    chk("clr_overrun", overrun, 1);
    chk("clr_ready", ready, 1);
    chk("clr_w0", dut.w_q[0], 0);
    chk("clr_x0", dut.x_q[0], 0);
    tick();
    chk("clr_overrun_end", overrun, 0);

    // Full LMS with an overrun strobe and late mode
    // change during MAC; both must be ignored.
    send(2'b10, 16'h1000, 16'h2000, 1, yo, eo);
    chk("lms1_latency", lat, 10);
    chk("lms1_y", yo, 16'h0000);
    chk("lms1_audio", eo, 16'h1000);
    chk("lms1_w0", dut.w_q[0], 32'h0080_0000);
    send(2'b10, 16'h1000, 16'h2000, 0, yo, eo);
    chk("lms2_y", yo, 16'h0040);
    chk("lms2_audio", eo, 16'h0FC0);

    // Reset in the middle of UPDATE.
    mode = 2'b10;
    primary_in = 16'h1000;
    ref_in = 16'h2000;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (12) tick();
    chk("mid_busy", ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_w0", dut.w_q[0], 0);
    chk("mid_rst_w1", dut.w_q[1], 0);
    chk("mid_rst_audio", audio_out, 0);

    // Drive weights to the positive rail.
    for (int i = 0; i < 12; i++)
      send(2'b01, 16'h7FFF, 16'h0001, 0, yo, eo);
    chk("sat_w0", dut.w_q[0], 32'h7FFF_FFFF);
    send(2'b00, 16'h8000, 16'h7FFF, 0, yo, eo);
    chk("sat_y", yo, 16'h7FFF);
    chk("sat_audio", eo, 16'h8000);
    chk("sat_w0_hold", dut.w_q[0], 32'h7FFF_FFFF);

    // Converge to primary = ref/2.
    clr();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      rs = int'($urandom_range(0, 24576)) - 12288;
      ph = rs >>> 1;
      send(2'b10, ph[15:0], rs[15:0], 0, yo, eo);
      es = eo;
      if (i >= 1900 && (es >= 16'sd64 || es <= -16'sd64))
        bad++;
    end
    w0 = int'(dut.w_q[0]);
    chk("conv_w0_range",
        (w0 >= 32'h1FF0_0000 && w0 <= 32'h2010_0000), 1);
    chk("conv_err_count", bad, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
